mfp_ahb_lite_arbiter_2m: RTL and testbench

MFP_AHB_LITE_ARBITER_2M -- requirements
Module: mfp_ahb_lite_arbiter_2m

---
 rtl/mfp_ahb_lite_arbiter_2m.sv | 168 ++++++++++++++++
 tb/tb_mfp_ahb_lite_arbiter_2m.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mfp_ahb_lite_arbiter_2m.sv
// Two-master AHB-Lite arbiter: M0 (core) normally wins, M1 (loader/DMA) is guaranteed a grant
// after MAX_HOLD contended M0 transfers. Stalled masters have completing data phases held.
module mfp_ahb_lite_arbiter_2m #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic        HCLK,
  input  logic        HRESETn,

  input  logic [31:0] M0_HADDR,
  input  logic [1:0]  M0_HTRANS,
  input  logic        M0_HWRITE,
  input  logic [2:0]  M0_HSIZE,
  input  logic [2:0]  M0_HBURST,
  input  logic [3:0]  M0_HPROT,
  input  logic        M0_HMASTLOCK,
  input  logic [31:0] M0_HWDATA,
  output logic [31:0] M0_HRDATA,
  output logic        M0_HREADY,
  output logic        M0_HRESP,

  input  logic [31:0] M1_HADDR,
  input  logic [1:0]  M1_HTRANS,
  input  logic        M1_HWRITE,
  input  logic [2:0]  M1_HSIZE,
  input  logic [2:0]  M1_HBURST,
  input  logic [3:0]  M1_HPROT,
  input  logic        M1_HMASTLOCK,
  input  logic [31:0] M1_HWDATA,
  output logic [31:0] M1_HRDATA,
  output logic        M1_HREADY,
  output logic        M1_HRESP,

  output logic [31:0] S_HADDR,
  output logic [1:0]  S_HTRANS,
  output logic        S_HWRITE,
  output logic [2:0]  S_HSIZE,
  output logic [2:0]  S_HBURST,
  output logic [3:0]  S_HPROT,
  output logic        S_HMASTLOCK,
  output logic [31:0] S_HWDATA,
  input  logic [31:0] S_HRDATA,
  input  logic        S_HREADY,
  input  logic        S_HRESP
);

  localparam logic [1:0] TrIdle   = 2'd0;
  localparam logic [1:0] TrBusy   = 2'd1;
  localparam logic [1:0] TrNonseq = 2'd2;
  localparam logic [1:0] TrSeq    = 2'd3;
  localparam logic [7:0] MaxHold  = MAX_HOLD[7:0];

  logic        own_q, own_d, dow_q, dow_d, dv_q, dv_d;
  logic [7:0]  hcnt_q, hcnt_d;
  logic [1:0]  pend_q, pend_d, hrs_q, hrs_d;
  logic [31:0] hrd0_q, hrd0_d, hrd1_q, hrd1_d;

  logic       ao, m0_ns, m1_ns, stall0, stall1, dph0, dph1, m0_ready, m1_ready;
  logic [1:0] own_trans, ao_trans;
  logic       own_lock;

  // Address owner: hold across bursts/locks, M0 priority with M1 fairness, else park.
  always_comb begin
    m0_ns     = (M0_HTRANS == TrNonseq);
    m1_ns     = (M1_HTRANS == TrNonseq);
    own_trans = own_q ? M1_HTRANS : M0_HTRANS;
    own_lock  = own_q ? M1_HMASTLOCK : M0_HMASTLOCK;
    ao        = own_q;
    if ((own_trans == TrSeq) || (own_trans == TrBusy) || (own_lock && (own_trans != TrIdle))) begin
      ao = own_q;
    end else if (m0_ns && !m1_ns) begin
      ao = 1'b0;
    end else if (m1_ns && !m0_ns) begin
      ao = 1'b1;
    end else if (m0_ns && m1_ns) begin
      ao = (hcnt_q >= MaxHold);
    end
    ao_trans = ao ? M1_HTRANS : M0_HTRANS;
  end

  always_comb begin
    S_HADDR     = ao ? M1_HADDR : M0_HADDR;
    S_HTRANS    = HRESETn ? ao_trans : TrIdle;
    S_HWRITE    = ao ? M1_HWRITE : M0_HWRITE;
    S_HSIZE     = ao ? M1_HSIZE : M0_HSIZE;
    S_HBURST    = ao ? M1_HBURST : M0_HBURST;
    S_HPROT     = ao ? M1_HPROT : M0_HPROT;
    S_HMASTLOCK = ao ? M1_HMASTLOCK : M0_HMASTLOCK;
    S_HWDATA    = dow_q ? M1_HWDATA : M0_HWDATA;
  end

  always_comb begin
    stall0   = m0_ns && ao;
    stall1   = m1_ns && !ao;
    dph0     = dv_q && !dow_q;
    dph1     = dv_q && dow_q;
    m0_ready = !HRESETn || (!stall0 && (!dph0 || S_HREADY));
    m1_ready = !HRESETn || (!stall1 && (!dph1 || S_HREADY));
    M0_HREADY = m0_ready;
    M1_HREADY = m1_ready;
    M0_HRDATA = pend_q[0] ? hrd0_q : S_HRDATA;
    M1_HRDATA = pend_q[1] ? hrd1_q : S_HRDATA;
    M0_HRESP  = HRESETn && (pend_q[0] ? hrs_q[0] : (dph0 && S_HRESP));
    M1_HRESP  = HRESETn && (pend_q[1] ? hrs_q[1] : (dph1 && S_HRESP));
  end

  always_comb begin
    own_d  = own_q;
    dow_d  = dow_q;
    dv_d   = dv_q;
    hcnt_d = hcnt_q;
    pend_d = pend_q;
    hrs_d  = hrs_q;
    hrd0_d = hrd0_q;
    hrd1_d = hrd1_q;

    if (S_HREADY) begin
      own_d = ao;
      dow_d = ao;
      dv_d  = (ao_trans == TrNonseq) || (ao_trans == TrSeq);
    end

    if ((M1_HTRANS == TrIdle) || (S_HREADY && ao && m1_ns)) begin
      hcnt_d = 8'd0;
    end else if (S_HREADY && !ao && m1_ns && (hcnt_q != 8'hFF) &&
                 ((M0_HTRANS == TrNonseq) || (M0_HTRANS == TrSeq))) begin
      hcnt_d = hcnt_q + 8'd1;
    end

    // A data phase completing under a stalled master is parked until that master is released.
    if (dph0 && S_HREADY && stall0) begin
      pend_d[0] = 1'b1;
      hrd0_d    = S_HRDATA;
      hrs_d[0]  = S_HRESP;
    end else if (m0_ready) begin
      pend_d[0] = 1'b0;
    end
    if (dph1 && S_HREADY && stall1) begin
      pend_d[1] = 1'b1;
      hrd1_d    = S_HRDATA;
      hrs_d[1]  = S_HRESP;
    end else if (m1_ready) begin
      pend_d[1] = 1'b0;
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      own_q  <= 1'b0;
      dow_q  <= 1'b0;
      dv_q   <= 1'b0;
      hcnt_q <= 8'd0;
      pend_q <= 2'b00;
      hrs_q  <= 2'b00;
      hrd0_q <= 32'd0;
      hrd1_q <= 32'd0;
    end else begin
      own_q  <= own_d;
      dow_q  <= dow_d;
      dv_q   <= dv_d;
      hcnt_q <= hcnt_d;
      pend_q <= pend_d;
      hrs_q  <= hrs_d;
      hrd0_q <= hrd0_d;
      hrd1_q <= hrd1_d;
    end
  end

endmodule

// File: tb/tb_mfp_ahb_lite_arbiter_2m.sv
// Directed bench for the two-master arbiter, built with MAX_HOLD=2 so fairness shows quickly.
module tb_mfp_ahb_lite_arbiter_2m;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [31:0] M0_HADDR, M1_HADDR, M0_HWDATA, M1_HWDATA, M0_HRDATA, M1_HRDATA;
  logic [1:0]  M0_HTRANS, M1_HTRANS;
  logic        M0_HWRITE, M1_HWRITE, M0_HMASTLOCK, M1_HMASTLOCK;
  logic [2:0]  M0_HSIZE, M1_HSIZE, M0_HBURST, M1_HBURST;
  logic [3:0]  M0_HPROT, M1_HPROT;
  logic        M0_HREADY, M1_HREADY, M0_HRESP, M1_HRESP;
  logic [31:0] S_HADDR, S_HWDATA, S_HRDATA;
  logic [1:0]  S_HTRANS;
  logic        S_HWRITE, S_HMASTLOCK, S_HREADY, S_HRESP;
  logic [2:0]  S_HSIZE, S_HBURST;
  logic [3:0]  S_HPROT;

  int checks = 0;
  int failures = 0;

  always #5 HCLK = ~HCLK;

  mfp_ahb_lite_arbiter_2m #(.MAX_HOLD(2)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .M0_HADDR(M0_HADDR), .M0_HTRANS(M0_HTRANS), .M0_HWRITE(M0_HWRITE), .M0_HSIZE(M0_HSIZE),
    .M0_HBURST(M0_HBURST), .M0_HPROT(M0_HPROT), .M0_HMASTLOCK(M0_HMASTLOCK),
    .M0_HWDATA(M0_HWDATA), .M0_HRDATA(M0_HRDATA), .M0_HREADY(M0_HREADY), .M0_HRESP(M0_HRESP),
    .M1_HADDR(M1_HADDR), .M1_HTRANS(M1_HTRANS), .M1_HWRITE(M1_HWRITE), .M1_HSIZE(M1_HSIZE),
    .M1_HBURST(M1_HBURST), .M1_HPROT(M1_HPROT), .M1_HMASTLOCK(M1_HMASTLOCK),
    .M1_HWDATA(M1_HWDATA), .M1_HRDATA(M1_HRDATA), .M1_HREADY(M1_HREADY), .M1_HRESP(M1_HRESP),
    .S_HADDR(S_HADDR), .S_HTRANS(S_HTRANS), .S_HWRITE(S_HWRITE), .S_HSIZE(S_HSIZE),
    .S_HBURST(S_HBURST), .S_HPROT(S_HPROT), .S_HMASTLOCK(S_HMASTLOCK), .S_HWDATA(S_HWDATA),
    .S_HRDATA(S_HRDATA), .S_HREADY(S_HREADY), .S_HRESP(S_HRESP)
  );

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic m0(input logic [1:0] tr, input logic [31:0] a);
    M0_HTRANS = tr;
    M0_HADDR  = a;
  endtask

  task automatic m1(input logic [1:0] tr, input logic [31:0] a);
    M1_HTRANS = tr;
    M1_HADDR  = a;
  endtask

  task automatic idle_all();
    m0(2'd0, 32'h0);
    m1(2'd0, 32'h0);
    M0_HMASTLOCK = 1'b0;
    M1_HMASTLOCK = 1'b0;
    S_HREADY = 1'b1;
    S_HRESP  = 1'b0;
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    idle_all();
    M0_HWRITE = 0; M1_HWRITE = 1; M0_HSIZE = 3'd2; M1_HSIZE = 3'd2;
    M0_HBURST = 0; M1_HBURST = 0; M0_HPROT = 4'h3; M1_HPROT = 4'h1;
    M0_HWDATA = 32'hA0A0_0000; M1_HWDATA = 32'hB1B1_0000; S_HRDATA = 32'h0;
    tick();
    m0(2'd2, 32'h1234); S_HRESP = 1'b1;
    #1;
    checks++; if (S_HTRANS !== 2'd0) begin failures++; $display("FAIL rst_htrans got %0d want 0", S_HTRANS); end
    checks++; if (M0_HREADY !== 1'b1) begin failures++; $display("FAIL rst_m0_hready got %b want 1", M0_HREADY); end
    checks++; if (M1_HREADY !== 1'b1) begin failures++; $display("FAIL rst_m1_hready got %b want 1", M1_HREADY); end
    checks++; if (M0_HRESP !== 1'b0) begin failures++; $display("FAIL rst_m0_hresp got %b want 0", M0_HRESP); end
    tick();
    checks++; if (dut.own_q !== 1'b0 || dut.dv_q !== 1'b0 || dut.pend_q !== 2'b00 || dut.hcnt_q !== 8'd0) begin
      failures++; $display("FAIL rst_state got own=%b dv=%b pend=%b hcnt=%0d want 0/0/00/0",
                           dut.own_q, dut.dv_q, dut.pend_q, dut.hcnt_q); end
    idle_all();
    HRESETn = 1'b1;
    tick();
  endtask

  task automatic test_single();
    m0(2'd2, 32'h1FC0_0000);
    #1;
    checks++; if (S_HADDR !== 32'h1FC0_0000 || S_HTRANS !== 2'd2) begin failures++;
      $display("FAIL single_addr got %h/%0d want 1fc00000/2", S_HADDR, S_HTRANS); end
    checks++; if (M1_HREADY !== 1'b1) begin failures++; $display("FAIL single_m1_ready_a got %b want 1", M1_HREADY); end
    tick();
    m0(2'd0, 32'h0);
    S_HRDATA = 32'h3C1C_0000;
    S_HREADY = 1'b0;
    #1;
    checks++; if (M0_HREADY !== 1'b0) begin failures++; $display("FAIL single_wait got %b want 0", M0_HREADY); end
    S_HREADY = 1'b1;
    #1;
    checks++; if (M0_HRDATA !== 32'h3C1C_0000 || M0_HREADY !== 1'b1) begin failures++;
      $display("FAIL single_rdata got %h/%b want 3c1c0000/1", M0_HRDATA, M0_HREADY); end
    checks++; if (M1_HREADY !== 1'b1) begin failures++; $display("FAIL single_m1_ready_d got %b want 1", M1_HREADY); end
    tick();
  endtask

  task automatic test_contention();
    m0(2'd2, 32'h100); m1(2'd2, 32'h200);
    #1;
    checks++; if (S_HADDR !== 32'h100 || M1_HREADY !== 1'b0) begin failures++;
      $display("FAIL cont_pt1 got %h/%b want 100/0", S_HADDR, M1_HREADY); end
    tick();
    m0(2'd2, 32'h104);
    #1;
    checks++; if (S_HADDR !== 32'h104 || M0_HREADY !== 1'b1) begin failures++;
      $display("FAIL cont_pt2 got %h/%b want 104/1", S_HADDR, M0_HREADY); end
    tick();
    m0(2'd2, 32'h108);
    S_HRDATA = 32'hDEAD_BEEF;
    #1;
    checks++; if (S_HADDR !== 32'h200 || M0_HREADY !== 1'b0 || M1_HREADY !== 1'b1) begin failures++;
      $display("FAIL cont_pt3 got %h/%b/%b want 200/0/1", S_HADDR, M0_HREADY, M1_HREADY); end
    tick();
    m1(2'd0, 32'h0);
    S_HRDATA = 32'h1111_1111;
    #1;
    checks++; if (dut.hcnt_q !== 8'd0 || dut.pend_q[0] !== 1'b1) begin failures++;
      $display("FAIL cont_hcnt_pend got %0d/%b want 0/1", dut.hcnt_q, dut.pend_q[0]); end
    checks++; if (M0_HRDATA !== 32'hDEAD_BEEF || M0_HREADY !== 1'b1) begin failures++;
      $display("FAIL held_rdata got %h/%b want deadbeef/1", M0_HRDATA, M0_HREADY); end
    checks++; if (M1_HRDATA !== 32'h1111_1111 || S_HADDR !== 32'h108) begin failures++;
      $display("FAIL cont_m1_data got %h/%h want 11111111/108", M1_HRDATA, S_HADDR); end
    tick();
    m0(2'd0, 32'h0);
    S_HRDATA = 32'h2222_2222;
    #1;
    checks++; if (dut.pend_q[0] !== 1'b0 || M0_HRDATA !== 32'h2222_2222) begin failures++;
      $display("FAIL held_clear got %b/%h want 0/22222222", dut.pend_q[0], M0_HRDATA); end
    tick();
  endtask

  task automatic test_locked_burst();
    m1(2'd2, 32'h300); M1_HMASTLOCK = 1'b1; M1_HBURST = 3'd3;
    #1;
    checks++; if (S_HADDR !== 32'h300 || S_HMASTLOCK !== 1'b1 || S_HBURST !== 3'd3 || S_HWRITE !== 1'b1) begin
      failures++; $display("FAIL lock_b1 got %h/%b/%0d/%b want 300/1/3/1",
                           S_HADDR, S_HMASTLOCK, S_HBURST, S_HWRITE); end
    tick();
    m1(2'd3, 32'h304); m0(2'd2, 32'h400);
    #1;
    checks++; if (S_HADDR !== 32'h304 || M0_HREADY !== 1'b0 || S_HWDATA !== 32'hB1B1_0000) begin failures++;
      $display("FAIL lock_b2 got %h/%b/%h want 304/0/b1b10000", S_HADDR, M0_HREADY, S_HWDATA); end
    tick();
    m1(2'd3, 32'h308); S_HREADY = 1'b0;
    #1;
    checks++; if (M1_HREADY !== 1'b0 || M0_HREADY !== 1'b0) begin failures++;
      $display("FAIL lock_wait got %b/%b want 0/0", M1_HREADY, M0_HREADY); end
    tick();
    S_HREADY = 1'b1;
    #1;
    checks++; if (S_HADDR !== 32'h308 || S_HPROT !== 4'h1) begin failures++;
      $display("FAIL lock_b3 got %h/%h want 308/1", S_HADDR, S_HPROT); end
    tick();
    m1(2'd3, 32'h30C);
    #1;
    checks++; if (S_HADDR !== 32'h30C || M0_HREADY !== 1'b0) begin failures++;
      $display("FAIL lock_b4 got %h/%b want 30c/0", S_HADDR, M0_HREADY); end
    tick();
    m1(2'd0, 32'h0); M1_HMASTLOCK = 1'b0; M1_HBURST = 3'd0;
    #1;
    checks++; if (S_HADDR !== 32'h400 || M0_HREADY !== 1'b1 || S_HWDATA !== 32'hB1B1_0000) begin failures++;
      $display("FAIL lock_release got %h/%b/%h want 400/1/b1b10000", S_HADDR, M0_HREADY, S_HWDATA); end
    tick();
    m0(2'd0, 32'h0);
    #1;
    checks++; if (S_HWDATA !== 32'hA0A0_0000 || S_HWRITE !== 1'b0) begin failures++;
      $display("FAIL wdata_m0 got %h/%b want a0a00000/0", S_HWDATA, S_HWRITE); end
    tick();
  endtask

  task automatic test_busy();
    m1(2'd2, 32'h500); M1_HBURST = 3'd1;
    tick();
    m1(2'd1, 32'h504); m0(2'd2, 32'h600);
    #1;
    checks++; if (S_HTRANS !== 2'd1 || S_HADDR !== 32'h504 || M0_HREADY !== 1'b0) begin failures++;
      $display("FAIL busy_pass got %0d/%h/%b want 1/504/0", S_HTRANS, S_HADDR, M0_HREADY); end
    tick();
    m1(2'd3, 32'h504); S_HREADY = 1'b0;
    #1;
    checks++; if (dut.dv_q !== 1'b0 || M1_HREADY !== 1'b1 || M0_HREADY !== 1'b0) begin failures++;
      $display("FAIL busy_nodata got %b/%b/%b want 0/1/0", dut.dv_q, M1_HREADY, M0_HREADY); end
    S_HREADY = 1'b1;
    tick();
    m1(2'd0, 32'h0); M1_HBURST = 3'd0;
    #1;
    checks++; if (S_HADDR !== 32'h600 || M0_HREADY !== 1'b1) begin failures++;
      $display("FAIL busy_handover got %h/%b want 600/1", S_HADDR, M0_HREADY); end
    tick();
    m0(2'd0, 32'h0);
    tick();
  endtask

  task automatic test_held_error();
    m0(2'd2, 32'h700); m1(2'd2, 32'h800);
    tick();
    m0(2'd2, 32'h704);
    tick();
    m0(2'd2, 32'h708); S_HREADY = 1'b0; S_HRESP = 1'b1;
    #1;
    checks++; if (S_HADDR !== 32'h800 || M0_HRESP !== 1'b1 || M0_HREADY !== 1'b0) begin failures++;
      $display("FAIL err_c1 got %h/%b/%b want 800/1/0", S_HADDR, M0_HRESP, M0_HREADY); end
    tick();
    S_HREADY = 1'b1;
    #1;
    checks++; if (M0_HRESP !== 1'b1 || M0_HREADY !== 1'b0) begin failures++;
      $display("FAIL err_c2 got %b/%b want 1/0", M0_HRESP, M0_HREADY); end
    tick();
    m1(2'd0, 32'h0); S_HRESP = 1'b0;
    #1;
    checks++; if (M0_HRESP !== 1'b1 || M0_HREADY !== 1'b1) begin failures++;
      $display("FAIL err_release got %b/%b want 1/1", M0_HRESP, M0_HREADY); end
    tick();
    m0(2'd0, 32'h0);
    #1;
    checks++; if (M0_HRESP !== 1'b0) begin failures++; $display("FAIL err_clear got %b want 0", M0_HRESP); end
    tick();
  endtask

  task automatic test_reset_mid_burst();
    m0(2'd2, 32'h900); m1(2'd2, 32'hA00); M1_HBURST = 3'd3;
    tick();
    m0(2'd2, 32'h904);
    tick();
    m0(2'd2, 32'h908); S_HRDATA = 32'hCAFE_F00D;
    tick();
    m1(2'd3, 32'hA04);
    #1;
    checks++; if (dut.pend_q[0] !== 1'b1 || S_HADDR !== 32'hA04) begin failures++;
      $display("FAIL rmb_pre got %b/%h want 1/a04", dut.pend_q[0], S_HADDR); end
    HRESETn = 1'b0;
    #1;
    checks++; if (S_HTRANS !== 2'd0 || M0_HREADY !== 1'b1 || M1_HREADY !== 1'b1) begin failures++;
      $display("FAIL rmb_in_reset got %0d/%b/%b want 0/1/1", S_HTRANS, M0_HREADY, M1_HREADY); end
    tick();
    HRESETn = 1'b1;
    idle_all(); M1_HBURST = 3'd0; S_HRDATA = 32'h5555_AAAA;
    #1;
    checks++; if (dut.pend_q !== 2'b00 || dut.own_q !== 1'b0 || S_HTRANS !== 2'd0) begin failures++;
      $display("FAIL rmb_post got %b/%b/%0d want 00/0/0", dut.pend_q, dut.own_q, S_HTRANS); end
    checks++; if (M0_HREADY !== 1'b1 || M1_HREADY !== 1'b1 || M0_HRDATA !== 32'h5555_AAAA) begin failures++;
      $display("FAIL rmb_ready got %b/%b/%h want 1/1/5555aaaa", M0_HREADY, M1_HREADY, M0_HRDATA); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_locked_burst();
    test_busy();
    test_held_error();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
